controlador_ciclo: RTL and testbench

Top-level sequencer for the washing machine. Walks one wash program through fill, wash, drain, rinse and spin, driving the valve, pump and motor actuators. Hands the rinse phase to the existing `enxaguar` block through a start/active handshake. Handles lid-open pause, fill timeout and program completion. Sits between the user panel (start, lid sensor, level sensor) and the phase datapath blocks.

---
 rtl/maquina_pkg.sv | 59 +++++
 rtl/temporizador_fase.sv | 31 +++
 rtl/controlador_ciclo.sv | 164 ++++++++++++++++
 tb/tb_controlador_ciclo.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maquina_pkg.sv
// Shared definitions for the washing-machine sequencer and its phase blocks:
// state codes, default phase durations and the registered output bundle.
package maquina_pkg;

   typedef enum logic [2:0] {
      OCIOSO      = 3'd0,
      ENCHER      = 3'd1,
      LAVAR       = 3'd2,
      ESVAZIAR    = 3'd3,
      ENXAGUAR    = 3'd4,
      CENTRIFUGAR = 3'd5,
      CONCLUIDO   = 3'd6,
      ERRO        = 3'd7
   } estado_t;

   localparam int LARGURA_PADRAO           = 4;
   localparam int TEMPO_ENCHER_MAX_PADRAO  = 12;
   localparam int TEMPO_LAVAR_PADRAO       = 8;
   localparam int TEMPO_ESVAZIAR_PADRAO    = 4;
   localparam int TEMPO_CENTRIFUGAR_PADRAO = 6;
   localparam int TEMPO_ENXAGUAR           = 5;

   typedef struct packed {
      logic inicia_enxaguar;
      logic valvula_agua;
      logic motor_lavar;
      logic motor_centrifugar;
      logic bomba;
      logic pausado;
      logic concluido;
      logic erro;
   } saidas_t;

   // Phases the lid can freeze; the rinse phase keeps its own timing.
   function automatic logic pausavel(input estado_t e);
      return (e == ENCHER) || (e == LAVAR) || (e == ESVAZIAR) || (e == CENTRIFUGAR);
   endfunction

   function automatic saidas_t decodifica(input estado_t e, input logic pausa);
      saidas_t s;
      s = '0;
      s.pausado = pausa;
      unique case (e)
         ENCHER:      s.valvula_agua = ~pausa;
         LAVAR:       s.motor_lavar  = ~pausa;
         ESVAZIAR:    s.bomba        = ~pausa;
         ENXAGUAR:    s.inicia_enxaguar = 1'b1;
         CENTRIFUGAR: begin
            s.motor_centrifugar = ~pausa;
            s.bomba             = ~pausa;
         end
         CONCLUIDO:   s.concluido = 1'b1;
         ERRO:        s.erro      = 1'b1;
         default:     s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/temporizador_fase.sv
// Phase timer: counts unpaused cycles inside one phase and flags the cycle
// whose edge ends the phase.
module temporizador_fase
   import maquina_pkg::*;
#(
   parameter int LARGURA = LARGURA_PADRAO
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               limpar,
   input  logic               contar,
   input  logic [LARGURA-1:0] limite,
   output logic               fim
);

   localparam logic [LARGURA-1:0] UM = LARGURA'(1);

   logic [LARGURA-1:0] contagem;

   always_ff @(posedge clock) begin
      if (reset || limpar) begin
         contagem <= '0;
      end else if (contar) begin
         contagem <= contagem + UM;
      end
   end

   // fim only on a counting cycle, so a paused cycle can never end a phase.
   assign fim = contar && (contagem == (limite - UM));

endmodule

// File: rtl/controlador_ciclo.sv
// Washing-machine program sequencer: fill, wash, drain, rinse handshake,
// spin, with lid pause, fill/rinse timeouts and latched fault.
module controlador_ciclo
   import maquina_pkg::*;
#(
   parameter int TEMPO_ENCHER_MAX  = TEMPO_ENCHER_MAX_PADRAO,
   parameter int TEMPO_LAVAR       = TEMPO_LAVAR_PADRAO,
   parameter int TEMPO_ESVAZIAR    = TEMPO_ESVAZIAR_PADRAO,
   parameter int TEMPO_CENTRIFUGAR = TEMPO_CENTRIFUGAR_PADRAO,
   parameter int LARGURA           = LARGURA_PADRAO
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       tampa_aberta,
   input  logic       nivel_cheio,
   input  logic       enxaguar_ativo,
   output logic       inicia_enxaguar,
   output logic       valvula_agua,
   output logic       motor_lavar,
   output logic       motor_centrifugar,
   output logic       bomba,
   output logic [2:0] fase,
   output logic       pausado,
   output logic       concluido,
   output logic       erro
);

   localparam logic [LARGURA-1:0] LIM_ENCHER      = LARGURA'(TEMPO_ENCHER_MAX);
   localparam logic [LARGURA-1:0] LIM_LAVAR       = LARGURA'(TEMPO_LAVAR);
   localparam logic [LARGURA-1:0] LIM_ESVAZIAR    = LARGURA'(TEMPO_ESVAZIAR);
   localparam logic [LARGURA-1:0] LIM_CENTRIFUGAR = LARGURA'(TEMPO_CENTRIFUGAR);

   estado_t            estado;
   estado_t            estado_prox;
   saidas_t            saidas;
   saidas_t            saidas_prox;
   logic               pausa_prox;
   logic               visto;
   logic               limpar;
   logic               contar;
   logic               fim;
   logic [LARGURA-1:0] limite;

   temporizador_fase #(
      .LARGURA (LARGURA)
   ) u_temporizador (
      .clock  (clock),
      .reset  (reset),
      .limpar (limpar),
      .contar (contar),
      .limite (limite),
      .fim    (fim)
   );

   // State and the whole output bundle are registered together, so every
   // actuator changes on the same edge as fase.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado <= OCIOSO;
         saidas <= '0;
      end else begin
         estado <= estado_prox;
         saidas <= saidas_prox;
      end
   end

   // Remembers that enxaguar acknowledged the start, so its falling edge
   // (not its initial low) is what ends the rinse phase.
   always_ff @(posedge clock) begin
      if (reset || limpar) begin
         visto <= 1'b0;
      end else if ((estado == ENXAGUAR) && enxaguar_ativo) begin
         visto <= 1'b1;
      end
   end

   // Timer control: cleared on every state change, counts unpaused cycles.
   always_comb begin
      limpar = (estado_prox != estado);
      contar = 1'b0;
      limite = LIM_ENCHER;
      unique case (estado)
         ENCHER: begin
            contar = ~tampa_aberta;
            limite = LIM_ENCHER;
         end
         LAVAR: begin
            contar = ~tampa_aberta;
            limite = LIM_LAVAR;
         end
         ESVAZIAR: begin
            contar = ~tampa_aberta;
            limite = LIM_ESVAZIAR;
         end
         ENXAGUAR: begin
            contar = ~visto;
            limite = LIM_ENCHER;
         end
         CENTRIFUGAR: begin
            contar = ~tampa_aberta;
            limite = LIM_CENTRIFUGAR;
         end
         default: begin
            contar = 1'b0;
            limite = LIM_ENCHER;
         end
      endcase
   end

   // Next state. An open lid freezes the pausable phases before any other rule.
   always_comb begin
      estado_prox = estado;
      unique case (estado)
         OCIOSO: begin
            if (start && !tampa_aberta) estado_prox = ENCHER;
         end
         ENCHER: begin
            if (!tampa_aberta) begin
               if (nivel_cheio)  estado_prox = LAVAR;
               else if (fim)     estado_prox = ERRO;
            end
         end
         LAVAR: begin
            if (!tampa_aberta && fim) estado_prox = ESVAZIAR;
         end
         ESVAZIAR: begin
            if (!tampa_aberta && fim) estado_prox = ENXAGUAR;
         end
         ENXAGUAR: begin
            if (!enxaguar_ativo && visto)             estado_prox = CENTRIFUGAR;
            else if (!enxaguar_ativo && !visto && fim) estado_prox = ERRO;
         end
         CENTRIFUGAR: begin
            if (!tampa_aberta && fim) estado_prox = CONCLUIDO;
         end
         CONCLUIDO: begin
            if (!start) estado_prox = OCIOSO;
         end
         ERRO: begin
            estado_prox = ERRO;
         end
         default: begin
            estado_prox = OCIOSO;
         end
      endcase
   end

   always_comb begin
      pausa_prox  = pausavel(estado) && tampa_aberta;
      saidas_prox = decodifica(estado_prox, pausa_prox);
   end

   assign fase              = estado;
   assign inicia_enxaguar   = saidas.inicia_enxaguar;
   assign valvula_agua      = saidas.valvula_agua;
   assign motor_lavar       = saidas.motor_lavar;
   assign motor_centrifugar = saidas.motor_centrifugar;
   assign bomba             = saidas.bomba;
   assign pausado           = saidas.pausado;
   assign concluido         = saidas.concluido;
   assign erro              = saidas.erro;

endmodule

// File: tb/tb_controlador_ciclo.sv
// Self-checking bench for controlador_ciclo: a phase/remaining-time model
// checked every cycle, plus directed scenarios with literal durations.
module tb_controlador_ciclo;

   logic       clock;
   logic       reset;
   logic       start;
   logic       tampa_aberta;
   logic       nivel_cheio;
   logic       enxaguar_ativo;
   logic       inicia_enxaguar;
   logic       valvula_agua;
   logic       motor_lavar;
   logic       motor_centrifugar;
   logic       bomba;
   logic [2:0] fase;
   logic       pausado;
   logic       concluido;
   logic       erro;
   logic [7:0] saidas_dut;

   int vectors;
   int errors;

   controlador_ciclo dut (
      .clock             (clock),
      .reset             (reset),
      .start             (start),
      .tampa_aberta      (tampa_aberta),
      .nivel_cheio       (nivel_cheio),
      .enxaguar_ativo    (enxaguar_ativo),
      .inicia_enxaguar   (inicia_enxaguar),
      .valvula_agua      (valvula_agua),
      .motor_lavar       (motor_lavar),
      .motor_centrifugar (motor_centrifugar),
      .bomba             (bomba),
      .fase              (fase),
      .pausado           (pausado),
      .concluido         (concluido),
      .erro              (erro)
   );

   assign saidas_dut = {inicia_enxaguar, valvula_agua, motor_lavar, motor_centrifugar,
                        bomba, pausado, concluido, erro};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_output(input string nome, input int atual, input int esperado);
      vectors++;
      if (atual != esperado) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", nome, atual, esperado, $time);
      end
   endtask

   // Stand-in for enxaguar: acknowledges one cycle after the start request,
   // stays active for TEMPO_ENXAGUAR cycles, then drops.
   bit stub_real;
   int stub_cnt;
   always @(negedge clock) begin
      if (stub_real && inicia_enxaguar) stub_cnt++;
      else stub_cnt = 0;
      enxaguar_ativo = stub_real && (stub_cnt >= 2) && (stub_cnt <= 6);
   end

   // Model: current phase, unpaused cycles still owed to it, pause and rinse ack.
   int m_fase;
   int m_rest;
   bit m_paus;
   bit m_visto;

   function automatic int duracao(input int p);
      case (p)
         1: return 12;
         2: return 8;
         3: return 4;
         4: return 12;
         5: return 6;
         default: return 0;
      endcase
   endfunction

   function automatic void entra(input int p);
      m_fase  = p;
      m_rest  = duracao(p);
      m_paus  = 1'b0;
      m_visto = 1'b0;
   endfunction

   function automatic void model_step();
      if (reset) begin
         entra(0);
      end else begin
         case (m_fase)
            0: if (start && !tampa_aberta) entra(1);
            1: begin
               if (tampa_aberta) m_paus = 1'b1;
               else if (nivel_cheio) entra(2);
               else begin
                  m_paus = 1'b0;
                  m_rest--;
                  if (m_rest == 0) entra(7);
               end
            end
            2, 3, 5: begin
               if (tampa_aberta) m_paus = 1'b1;
               else begin
                  m_paus = 1'b0;
                  m_rest--;
                  if (m_rest == 0) entra(m_fase == 5 ? 6 : m_fase + 1);
               end
            end
            4: begin
               if (enxaguar_ativo) m_visto = 1'b1;
               else if (m_visto) entra(5);
               else begin
                  m_rest--;
                  if (m_rest == 0) entra(7);
               end
            end
            6: if (!start) entra(0);
            default: m_fase = 7;
         endcase
      end
   endfunction

   function automatic logic [7:0] esperado_saidas();
      logic ativo;
      ativo = !m_paus;
      return {m_fase == 4, (m_fase == 1) && ativo, (m_fase == 2) && ativo,
              (m_fase == 5) && ativo, ((m_fase == 3) || (m_fase == 5)) && ativo,
              m_paus, m_fase == 6, m_fase == 7};
   endfunction

   // Observed phase history, used by the directed duration checks.
   int cnt [8];
   int seq [$];
   int ultima_fase = 0;

   always @(posedge clock) begin
      model_step();
      #1;
      check_output("fase", int'(fase), m_fase);
      check_output("saidas", int'(saidas_dut), int'(esperado_saidas()));
      if (int'(fase) != ultima_fase) seq.push_back(int'(fase));
      ultima_fase = int'(fase);
      cnt[fase]++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic limpa_stats();
      seq.delete();
      for (int i = 0; i < 8; i++) cnt[i] = 0;
   endtask

   task automatic wait_fase(input int alvo, input int limite);
      int n;
      n = 0;
      while ((int'(fase) != alvo) && (n < limite)) begin
         @(negedge clock);
         n++;
      end
      check_output("espera_fase", int'(fase), alvo);
   endtask

   task automatic do_reset();
      @(negedge clock);
      start        = 1'b0;
      tampa_aberta = 1'b0;
      nivel_cheio  = 1'b0;
      reset        = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic check_seq();
      check_output("seq_tamanho", seq.size(), 6);
      for (int i = 0; i < 6; i++)
         check_output("seq_fase", (i < seq.size()) ? seq[i] : -1, i + 1);
   endtask

   task automatic apply_stimulus();
      // Reset state
      tick(2);
      reset = 1'b0;
      @(negedge clock);
      check_output("reset_fase", int'(fase), 0);
      check_output("reset_saidas", int'(saidas_dut), 0);

      // Nominal run, level full on fill cycle 3
      limpa_stats();
      start = 1'b1;
      wait_fase(1, 5);
      tick(2);
      nivel_cheio = 1'b1;
      wait_fase(2, 5);
      nivel_cheio = 1'b0;
      wait_fase(6, 80);
      check_output("dur_encher", cnt[1], 3);
      check_output("dur_lavar", cnt[2], 8);
      check_output("dur_esvaziar", cnt[3], 4);
      check_output("dur_enxaguar", cnt[4], 7);
      check_output("dur_centrifugar", cnt[5], 6);
      check_seq();
      tick(3);
      check_output("concluido_mantido", int'(concluido), 1);
      start = 1'b0;
      tick(1);
      check_output("volta_ocioso", int'(fase), 0);

      // Fill timeout
      do_reset();
      limpa_stats();
      start = 1'b1;
      wait_fase(7, 40);
      check_output("timeout_encher", cnt[1], 12);
      tick(5);
      check_output("erro_fase", int'(fase), 7);
      check_output("erro_flag", int'(erro), 1);

      // Lid pause at wash cycle 3 for 5 cycles
      do_reset();
      limpa_stats();
      start = 1'b1;
      wait_fase(1, 5);
      nivel_cheio = 1'b1;
      wait_fase(2, 5);
      nivel_cheio = 1'b0;
      tick(2);
      check_output("lavar_antes_pausa", int'(motor_lavar), 1);
      tampa_aberta = 1'b1;
      tick(1);
      check_output("pausa_motor", int'(motor_lavar), 0);
      check_output("pausa_flag", int'(pausado), 1);
      tick(4);
      tampa_aberta = 1'b0;
      wait_fase(3, 30);
      check_output("lavar_com_pausa", cnt[2], 13);

      // Start request with lid open
      do_reset();
      tampa_aberta = 1'b1;
      start = 1'b1;
      tick(4);
      check_output("start_tampa_aberta", int'(fase), 0);
      tampa_aberta = 1'b0;
      tick(1);
      check_output("start_tampa_fechada", int'(fase), 1);

      // Rinse handshake never acknowledged
      do_reset();
      limpa_stats();
      stub_real = 1'b0;
      start = 1'b1;
      wait_fase(1, 5);
      nivel_cheio = 1'b1;
      wait_fase(4, 30);
      nivel_cheio = 1'b0;
      wait_fase(7, 30);
      check_output("timeout_enxaguar", cnt[4], 12);
      check_output("enxaguar_erro", int'(erro), 1);

      // Reset mid-spin, then a full program with a drain pause
      do_reset();
      stub_real = 1'b1;
      start = 1'b1;
      wait_fase(1, 5);
      nivel_cheio = 1'b1;
      wait_fase(5, 60);
      tick(2);
      reset = 1'b1;
      nivel_cheio = 1'b0;
      tick(1);
      check_output("reset_meio_fase", int'(fase), 0);
      check_output("reset_meio_saidas", int'(saidas_dut), 0);
      check_output("reset_meio_inicia", int'(inicia_enxaguar), 0);
      reset = 1'b0;
      limpa_stats();
      wait_fase(1, 5);
      tick(1);
      nivel_cheio = 1'b1;
      wait_fase(3, 20);
      nivel_cheio = 1'b0;
      tampa_aberta = 1'b1;
      tick(2);
      tampa_aberta = 1'b0;
      wait_fase(6, 80);
      check_output("dur_encher_k2", cnt[1], 2);
      check_output("esvaziar_com_pausa", cnt[3], 6);
      check_seq();
      start = 1'b0;
      tick(1);
      check_output("fim_ocioso", int'(fase), 0);
   endtask

   initial begin
      vectors      = 0;
      errors       = 0;
      reset        = 1'b1;
      start        = 1'b0;
      tampa_aberta = 1'b0;
      nivel_cheio  = 1'b0;
      stub_real    = 1'b1;
      apply_stimulus();
      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
